fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter with burst locking that shares the single write port of the CDC async FIFO among NREQ write-domain requesters.
- Sits entirely in the FIFO write clock domain. Drives the FIFO's winc/wdata and honours its wfull.
- Each requester uses a valid/ready handshake. Grants are burst-locked up to MAX_BURST beats to amortise arbitration.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/rr_priority_pick.sv | 17 +
 rtl/fifo_wr_arbiter.sv | 83 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and round-robin search helper for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int MAX_NREQ = 8;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Walk backwards so the first set bit at or after start is the one kept.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid, input int start, input int n);
    pick_t p;
    int j;
    p = '0;
    for (int k = n - 1; k >= 0; k--) begin
      j = (start + k) % n;
      if (valid[j]) begin
        p.found = 1'b1;
        p.idx = 3'(j);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotate-and-find-first over NREQ valid bits.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   start,
  output logic            found,
  output logic [IW-1:0]   idx
);
  pick_t p;
  assign p = rr_pick(MAX_NREQ'(valid), int'(start), NREQ);
  assign found = p.found;
  assign idx = IW'(p.idx);
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst-locked round-robin sharing of the async FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DSIZE = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W = 16,
  localparam int IW = idx_w(NREQ)
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IW-1:0]         grant_id,
  output logic                  burst_active,
  output logic [CNT_W-1:0]      wr_count
);
  state_t state;
  logic [IW-1:0] owner, last, start, pick_idx, winner;
  logic [3:0] beat_cnt, beat_next;
  logic found, owner_hold, has_win, fire;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction
  // A dropped owner hands over starting just past itself, otherwise past the last winner.
  assign owner_hold = (state == BURST) && req_valid[owner];
  assign start = nxt((state == BURST) ? owner : last);
  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .valid(req_valid),
    .start(start),
    .found(found),
    .idx(pick_idx)
  );
  assign winner = owner_hold ? owner : pick_idx;
  assign has_win = owner_hold || found;
  assign fire = has_win && !wfull && !rst;
  assign winc = fire;
  assign req_ready = fire ? NREQ'(1) << winner : '0;
  assign grant_id = (rst || !has_win) ? '0 : winner;
  assign wdata = (rst || !has_win) ? '0 : req_data[winner*DSIZE +: DSIZE];
  assign burst_active = (state == BURST);
  assign beat_next = beat_cnt + 4'd1;
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last <= IW'(NREQ - 1);
      beat_cnt <= '0;
      wr_count <= '0;
    end else begin
      if (fire) wr_count <= wr_count + 1'b1;
      if (state == IDLE) begin
        if (fire) begin
          owner <= winner;
          beat_cnt <= 4'd1;
          if (MAX_BURST == 1) last <= winner;
          else state <= BURST;
        end
      end else if (owner_hold) begin
        if (fire) begin
          if (beat_next == 4'(MAX_BURST)) begin
            state <= IDLE;
            last <= owner;
            beat_cnt <= '0;
          end else beat_cnt <= beat_next;
        end
      end else if (fire) begin
        owner <= winner;
        beat_cnt <= 4'd1;
        last <= owner;
      end else if (!found) begin
        state <= IDLE;
        last <= owner;
        beat_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven check of the FIFO write arbiter plus an async-reset sequence.
module tb_fifo_wr_arbiter;
  logic wclk, rst, wfull, winc, burst_active;
  logic [3:0] req_valid, req_ready, wdata;
  logic [15:0] req_data, wr_count;
  logic [1:0] grant_id;
  int checks = 0, errors = 0;
  localparam logic [15:0] D1 = 16'h8421;
  localparam logic [15:0] D6 = 16'h8426;
  typedef struct {
    logic rst;
    logic [3:0] v;
    logic [15:0] d;
    logic f;
    logic winc;
    logic [3:0] rdy;
    logic [1:0] gid;
    logic [3:0] wd;
    logic ba;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[$];
  fifo_wr_arbiter #(.NREQ(4), .DSIZE(4), .MAX_BURST(4), .CNT_W(16)) dut (
    .wclk(wclk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .wfull(wfull),
    .winc(winc),
    .wdata(wdata),
    .grant_id(grant_id),
    .burst_active(burst_active),
    .wr_count(wr_count)
  );
  initial wclk = 0;
  always #5 wclk = ~wclk;
  function automatic vec_t mk(input logic r, input int v, input logic [15:0] d, input logic f,
                              input logic w, input int rd, input int g, input int wd,
                              input logic ba, input int c);
    vec_t x;
    x.rst = r; x.v = 4'(v); x.d = d; x.f = f; x.winc = w; x.rdy = 4'(rd);
    x.gid = 2'(g); x.wd = 4'(wd); x.ba = ba; x.cnt = 16'(c);
    return x;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    rst = 1; req_valid = 0; req_data = D1; wfull = 0;
    // reset, including valid requests that must not leak through
    vecs.push_back(mk(1, 0, D1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, D1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 15, D1, 0, 0, 0, 0, 0, 0, 0));
    // single requester: 4-beat burst, then bubble-free re-grant
    for (int k = 0; k < 6; k++) vecs.push_back(mk(0, 1, D6, 0, 1, 1, 0, 6, (k != 0 && k != 4), k));
    vecs.push_back(mk(0, 0, D6, 0, 0, 0, 0, 0, 1, 6));
    vecs.push_back(mk(1, 0, D1, 0, 0, 0, 0, 0, 0, 0));
    // all four valid: 0000 1111 2222 3333 0
    for (int k = 0; k < 17; k++) begin
      int g;
      g = (k / 4) % 4;
      vecs.push_back(mk(0, 15, D1, 0, 1, 1 << g, g, 1 << g, (k % 4) != 0, k));
    end
    vecs.push_back(mk(0, 0, D1, 0, 0, 0, 0, 0, 1, 17));
    // wfull stall after beat 2, burst resumes, then release lets req1 in
    vecs.push_back(mk(0, 1, D1, 0, 1, 1, 0, 1, 0, 17));
    vecs.push_back(mk(0, 1, D1, 0, 1, 1, 0, 1, 1, 18));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 1, D1, 1, 0, 0, 0, 0, 1, 19));
    vecs.push_back(mk(0, 1, D1, 0, 1, 1, 0, 1, 1, 19));
    vecs.push_back(mk(0, 1, D1, 0, 1, 1, 0, 1, 1, 20));
    vecs.push_back(mk(0, 3, D1, 0, 1, 2, 1, 2, 0, 21));
    vecs.push_back(mk(0, 0, D1, 0, 0, 0, 0, 0, 1, 22));
    vecs.push_back(mk(1, 0, D1, 0, 0, 0, 0, 0, 0, 0));
    // owner drop: same-cycle handover 0->2, then 2->3 searched from owner+1
    vecs.push_back(mk(0, 5, D1, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4, D1, 0, 1, 4, 2, 4, 1, 1));
    vecs.push_back(mk(0, 10, D1, 0, 1, 8, 3, 8, 1, 2));
    vecs.push_back(mk(0, 0, D1, 0, 0, 0, 0, 0, 1, 3));
    foreach (vecs[i]) begin
      @(posedge wclk);
      #1;
      rst = vecs[i].rst; req_valid = vecs[i].v; req_data = vecs[i].d; wfull = vecs[i].f;
      @(negedge wclk);
      chk($sformatf("vec%0d_ctl", i), {winc, req_ready, burst_active, wr_count},
          {vecs[i].winc, vecs[i].rdy, vecs[i].ba, vecs[i].cnt});
      if (vecs[i].winc || vecs[i].rst)
        chk($sformatf("vec%0d_data", i), {grant_id, wdata}, {vecs[i].gid, vecs[i].wd});
    end
    // async reset between edges during beat 2
    @(posedge wclk);
    #1;
    rst = 0; req_valid = 4'b0001; req_data = D1; wfull = 0;
    @(negedge wclk);
    chk("rstmb_beat1", {winc, req_ready, grant_id, burst_active, wr_count}, {1'b1, 4'b0001, 2'd0, 1'b0, 16'd3});
    @(posedge wclk);
    @(negedge wclk);
    chk("rstmb_beat2", {winc, req_ready, grant_id, burst_active, wr_count}, {1'b1, 4'b0001, 2'd0, 1'b1, 16'd4});
    #2 rst = 1;
    #1 chk("rstmb_async", {winc, req_ready, burst_active, wdata, grant_id, wr_count}, 64'd0);
    @(posedge wclk);
    #1;
    rst = 0; req_valid = 4'b0011;
    @(negedge wclk);
    chk("rstmb_regrant", {winc, req_ready, grant_id, wdata, burst_active, wr_count},
        {1'b1, 4'b0001, 2'd0, 4'd1, 1'b0, 16'd0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
